// File: rtl/ps2_hack2scancode.sv
// Hack character code to PS/2 Scan Code Set 2 keystroke generator.
// Accepts one Hack code and emits the full make/break byte sequence:
//   plain:    code, F0, code
//   prefixed: E0, code, E0, F0, code
// with HOLD_CYCLES idle cycles between the make and break halves.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   hack         Hack character code to type
//   hack_valid   hack is valid
//   hack_ready   block can accept a character (IDLE and out of reset)
//   scan_code    registered PS/2 byte to transmit
//   scan_valid   registered, scan_code is valid
//   scan_ready   downstream accepts scan_code
//   busy         keystroke sequence in progress
//   unsupported  one-cycle pulse after accepting an unmapped character
module ps2_hack2scancode #(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] hack,
    input  logic       hack_valid,
    output logic       hack_ready,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    input  logic       scan_ready,
    output logic       busy,
    output logic       unsupported
);

    typedef enum logic [2:0] {
        StIdle,
        StMkE0,
        StMk,
        StHold,
        StBkE0,
        StBkF0,
        StBk
    } state_e;

    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CntW-1:0] HoldLast = CntW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

    state_e          state_q, state_d;
    logic            valid_q, valid_d;
    logic [7:0]      out_q, out_d;
    logic [7:0]      code_q, code_d;
    logic            ext_q, ext_d;
    logic [CntW-1:0] hold_q, hold_d;
    logic            unsup_q, unsup_d;

    logic            map_ok;
    logic            map_ext;
    logic [7:0]      map_code;
    logic            accept;
    logic            handshake;
    state_e          brk_state;
    logic [7:0]      brk_byte;

    // Inverse of the decoder table.
    always_comb begin
        map_ok   = 1'b1;
        map_ext  = 1'b0;
        map_code = 8'h00;
        case (hack)
            8'h61: map_code = 8'h1C;  // a
            8'h62: map_code = 8'h32;
            8'h63: map_code = 8'h21;
            8'h64: map_code = 8'h23;
            8'h65: map_code = 8'h24;
            8'h66: map_code = 8'h2B;
            8'h67: map_code = 8'h34;
            8'h68: map_code = 8'h33;
            8'h69: map_code = 8'h43;
            8'h6A: map_code = 8'h3B;
            8'h6B: map_code = 8'h42;
            8'h6C: map_code = 8'h4B;
            8'h6D: map_code = 8'h3A;
            8'h6E: map_code = 8'h31;
            8'h6F: map_code = 8'h44;
            8'h70: map_code = 8'h4D;
            8'h71: map_code = 8'h15;
            8'h72: map_code = 8'h2D;
            8'h73: map_code = 8'h1B;
            8'h74: map_code = 8'h2C;
            8'h75: map_code = 8'h3C;
            8'h76: map_code = 8'h2A;
            8'h77: map_code = 8'h1D;
            8'h78: map_code = 8'h22;
            8'h79: map_code = 8'h35;
            8'h7A: map_code = 8'h1A;  // z
            8'h31: map_code = 8'h16;  // 1
            8'h32: map_code = 8'h1E;
            8'h33: map_code = 8'h26;
            8'h34: map_code = 8'h25;
            8'h35: map_code = 8'h2E;
            8'h36: map_code = 8'h36;
            8'h37: map_code = 8'h3D;
            8'h38: map_code = 8'h3E;
            8'h39: map_code = 8'h46;
            8'h30: map_code = 8'h45;  // 0
            8'h20: map_code = 8'h29;  // space
            8'h0D: map_code = 8'h5A;  // enter
            8'h08: map_code = 8'h66;  // backspace
            8'h09: map_code = 8'h0D;  // tab
            8'h2D: map_code = 8'h4E;  // -
            8'h3D: map_code = 8'h55;  // =
            8'h5C: map_code = 8'h5D;  // backslash
            8'h5B: map_code = 8'h54;  // [
            8'h5D: map_code = 8'h5B;  // ]
            8'h3B: map_code = 8'h4C;  // ;
            8'h27: map_code = 8'h52;  // quote
            8'h2C: map_code = 8'h41;  // ,
            8'h2E: map_code = 8'h49;  // .
            8'h2F: map_code = 8'h4A;  // /
            8'd130: begin map_ext = 1'b1; map_code = 8'h6B; end
            8'd131: begin map_ext = 1'b1; map_code = 8'h75; end
            8'd132: begin map_ext = 1'b1; map_code = 8'h74; end
            8'd133: begin map_ext = 1'b1; map_code = 8'h72; end
            8'd134: begin map_ext = 1'b1; map_code = 8'h6C; end
            8'd135: begin map_ext = 1'b1; map_code = 8'h69; end
            8'd136: begin map_ext = 1'b1; map_code = 8'h7D; end
            8'd137: begin map_ext = 1'b1; map_code = 8'h7A; end
            8'd138: begin map_ext = 1'b1; map_code = 8'h70; end
            8'd139: begin map_ext = 1'b1; map_code = 8'h71; end
            default: map_ok = 1'b0;
        endcase
    end

    assign hack_ready  = (state_q == StIdle) && rst_n;
    assign busy        = (state_q != StIdle);
    assign scan_valid  = valid_q;
    assign scan_code   = out_q;
    assign unsupported = unsup_q;

    assign accept    = hack_valid && hack_ready;
    assign handshake = valid_q && scan_ready;
    assign brk_state = ext_q ? StBkE0 : StBkF0;
    assign brk_byte  = ext_q ? 8'hE0 : 8'hF0;

    // Output byte is computed together with the next state so it is registered
    // and appears in the same cycle the state is entered.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        out_d   = out_q;
        code_d  = code_q;
        ext_d   = ext_q;
        hold_d  = hold_q;
        unsup_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (map_ok) begin
                        code_d  = map_code;
                        ext_d   = map_ext;
                        valid_d = 1'b1;
                        state_d = map_ext ? StMkE0 : StMk;
                        out_d   = map_ext ? 8'hE0 : map_code;
                    end else begin
                        unsup_d = 1'b1;
                    end
                end
            end
            StMkE0: begin
                if (handshake) begin
                    state_d = StMk;
                    out_d   = code_q;
                end
            end
            StMk: begin
                if (handshake) begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = brk_state;
                        out_d   = brk_byte;
                    end else begin
                        state_d = StHold;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end
            end
            StHold: begin
                if (hold_q == HoldLast) begin
                    state_d = brk_state;
                    valid_d = 1'b1;
                    out_d   = brk_byte;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StBkE0: begin
                if (handshake) begin
                    state_d = StBkF0;
                    out_d   = 8'hF0;
                end
            end
            StBkF0: begin
                if (handshake) begin
                    state_d = StBk;
                    out_d   = code_q;
                end
            end
            StBk: begin
                if (handshake) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            out_q   <= 8'h00;
            code_q  <= 8'h00;
            ext_q   <= 1'b0;
            hold_q  <= '0;
            unsup_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            code_q  <= code_d;
            ext_q   <= ext_d;
            hold_q  <= hold_d;
            unsup_q <= unsup_d;
        end
    end

endmodule

// File: tb/tb_ps2_hack2scancode.sv
// Bench for ps2_hack2scancode: directed trace checks plus a randomized
// loopback through a behavioural Set 2 decoder. Two instances share inputs:
// dut (HOLD_CYCLES=4) and dut_z (HOLD_CYCLES=0).
module tb_ps2_hack2scancode;

    localparam int unsigned Hold = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] hack = 8'h00;
    logic       hack_valid = 1'b0;
    logic       scan_ready = 1'b0;

    logic       hack_ready, scan_valid, busy, unsupported;
    logic [7:0] scan_code;
    logic       z_ready, z_valid, z_busy, z_unsup;
    logic [7:0] z_code;

    int errors = 0;
    int checks = 0;

    ps2_hack2scancode #(.HOLD_CYCLES(Hold)) dut (
        .clk(clk), .rst_n(rst_n), .hack(hack), .hack_valid(hack_valid),
        .hack_ready(hack_ready), .scan_code(scan_code), .scan_valid(scan_valid),
        .scan_ready(scan_ready), .busy(busy), .unsupported(unsupported)
    );

    ps2_hack2scancode #(.HOLD_CYCLES(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .hack(hack), .hack_valid(hack_valid),
        .hack_ready(z_ready), .scan_code(z_code), .scan_valid(z_valid),
        .scan_ready(scan_ready), .busy(z_busy), .unsupported(z_unsup)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference tables ----------------
    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
    logic [7:0] digit_ch [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                                  8'h39, 8'h30};
    logic [7:0] digit_sc [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                  8'h46, 8'h45};
    logic [7:0] misc_ch [14] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h2D, 8'h3D, 8'h5C, 8'h5B,
                                 8'h5D, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
    logic [7:0] misc_sc [14] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h4E, 8'h55, 8'h5D, 8'h54,
                                 8'h5B, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
    logic [7:0] ext_sc [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A,
                                8'h70, 8'h71};

    bit         enc_ok  [256];
    bit         enc_ext [256];
    logic [7:0] enc_sc  [256];
    bit         decp_ok [256];
    logic [7:0] decp    [256];
    bit         dece_ok [256];
    logic [7:0] dece    [256];
    logic [7:0] mapped [$];

    task automatic add_map(input logic [7:0] ch, input logic [7:0] sc, input bit ext);
        enc_ok[ch] = 1'b1; enc_ext[ch] = ext; enc_sc[ch] = sc;
        if (ext) begin dece_ok[sc] = 1'b1; dece[sc] = ch; end
        else     begin decp_ok[sc] = 1'b1; decp[sc] = ch; end
        mapped.push_back(ch);
    endtask

    task automatic init_tables();
        for (int i = 0; i < 256; i++) begin
            enc_ok[i] = 0; enc_ext[i] = 0; enc_sc[i] = 0;
            decp_ok[i] = 0; decp[i] = 0; dece_ok[i] = 0; dece[i] = 0;
        end
        for (int i = 0; i < 26; i++) add_map(8'(8'h61 + i), letter_sc[i], 1'b0);
        for (int i = 0; i < 10; i++) add_map(digit_ch[i], digit_sc[i], 1'b0);
        for (int i = 0; i < 14; i++) add_map(misc_ch[i], misc_sc[i], 1'b0);
        for (int i = 0; i < 10; i++) add_map(8'(130 + i), ext_sc[i], 1'b1);
    endtask

    // Expected byte list for one keystroke.
    logic [7:0] exp_q [$];
    task automatic expect_bytes(input logic [7:0] h);
        exp_q.delete();
        if (enc_ext[h]) exp_q = '{8'hE0, enc_sc[h], 8'hE0, 8'hF0, enc_sc[h]};
        else            exp_q = '{enc_sc[h], 8'hF0, enc_sc[h]};
    endtask

    // Behavioural Set 2 decoder: returns (hack, pressed) events.
    logic [7:0] ev_h [$];
    bit         ev_p [$];
    task automatic decode(input logic [7:0] q [$]);
        bit ext = 0;
        bit brk = 0;
        ev_h.delete(); ev_p.delete();
        foreach (q[i]) begin
            if (q[i] == 8'hE0) ext = 1;
            else if (q[i] == 8'hF0) brk = 1;
            else begin
                if (ext) ev_h.push_back(dece_ok[q[i]] ? dece[q[i]] : 8'h00);
                else     ev_h.push_back(decp_ok[q[i]] ? decp[q[i]] : 8'h00);
                ev_p.push_back(!brk);
                ext = 0; brk = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte capture at each accepted handshake.
    logic [7:0] q_a [$];
    logic [7:0] q_z [$];
    bit         stall_p = 0;
    logic [7:0] stall_code = 8'h00;
    always @(posedge clk) begin
        if (rst_n && scan_valid && scan_ready) q_a.push_back(scan_code);
        if (rst_n && z_valid && scan_ready) q_z.push_back(z_code);
        if (stall_p && rst_n) begin
            check("stall_valid", {7'd0, scan_valid}, 8'd1);
            check("stall_code", scan_code, stall_code);
        end
        stall_p    = rst_n && scan_valid && !scan_ready;
        stall_code = scan_code;
    end

    task automatic send(input logic [7:0] h);
        int n = 0;
        while (!(hack_ready && z_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", {7'd0, hack_ready && z_ready}, 8'd1);
        hack = h;
        hack_valid = 1'b1;
        @(negedge clk);
        hack_valid = 1'b0;
    endtask

    // mode 0: ready=1, 1: pattern 1-0-0-1, 2: random
    task automatic wait_idle(input int mode);
        int n = 0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        while ((busy || z_busy || scan_valid || z_valid) && n < 500) begin
            if (mode == 1) scan_ready = pat[n % 4];
            else if (mode == 2) scan_ready = 1'($urandom_range(0, 1));
            else scan_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        scan_ready = 1'b1;
        check("idle_timeout", {7'd0, busy || z_busy}, 8'd0);
    endtask

    task automatic compare_q(input string tag, input logic [7:0] q [$]);
        check({tag, "_len"}, 8'(q.size()), 8'(exp_q.size()));
        if (q.size() == exp_q.size())
            foreach (q[i]) check({tag, "_byte"}, q[i], exp_q[i]);
    endtask

    // Cycle-exact trace against dut with scan_ready held at 1.
    task automatic run_trace(input logic [7:0] h);
        bit         tv [$];
        logic [7:0] tc [$];
        int         mk;
        expect_bytes(h);
        mk = enc_ext[h] ? 2 : 1;
        for (int i = 0; i < mk; i++) begin tv.push_back(1); tc.push_back(exp_q[i]); end
        for (int i = 0; i < int'(Hold); i++) begin tv.push_back(0); tc.push_back(8'h00); end
        for (int i = mk; i < exp_q.size(); i++) begin tv.push_back(1); tc.push_back(exp_q[i]); end
        scan_ready = 1'b1;
        send(h);
        foreach (tv[i]) begin
            check("trace_valid", {7'd0, scan_valid}, {7'd0, tv[i]});
            if (tv[i]) check("trace_code", scan_code, tc[i]);
            check("trace_busy", {7'd0, busy}, 8'd1);
            check("trace_ready", {7'd0, hack_ready}, 8'd0);
            @(negedge clk);
        end
        check("end_valid", {7'd0, scan_valid}, 8'd0);
        check("end_busy", {7'd0, busy}, 8'd0);
        check("end_ready", {7'd0, hack_ready}, 8'd1);
        wait_idle(0);
    endtask

    initial begin
        logic [7:0] order [$];
        logic [7:0] tmp;
        logic [7:0] u;
        int j;
        init_tables();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", {7'd0, scan_valid}, 8'd0);
        check("rst_code", scan_code, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_unsup", {7'd0, unsupported}, 8'd0);
        check("rst_hready", {7'd0, hack_ready}, 8'd0);
        check("rst_z_valid", {7'd0, z_valid}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_hready", {7'd0, hack_ready}, 8'd1);

        // Plain and prefixed keystrokes, cycle-exact
        run_trace(8'h61);
        run_trace(8'd130);

        // Stalls with ready pattern 1-0-0-1
        q_a.delete(); q_z.delete();
        scan_ready = 1'b1;
        send(8'h30);
        wait_idle(1);
        expect_bytes(8'h30);
        compare_q("stall", q_a);
        compare_q("stall_z", q_z);

        // Unsupported then a valid character
        send(8'h41);
        check("unsup_pulse", {7'd0, unsupported}, 8'd1);
        check("unsup_valid", {7'd0, scan_valid}, 8'd0);
        check("unsup_busy", {7'd0, busy}, 8'd0);
        check("unsup_hready", {7'd0, hack_ready}, 8'd1);
        @(negedge clk);
        check("unsup_once", {7'd0, unsupported}, 8'd0);
        q_a.delete(); q_z.delete();
        send(8'h20);
        wait_idle(0);
        expect_bytes(8'h20);
        compare_q("space", q_a);
        compare_q("space_z", q_z);

        // Reset while a prefixed break E0 is stalled
        q_a.delete();
        scan_ready = 1'b1;
        send(8'd130);
        j = 0;
        while (q_a.size() < 2 && j < 50) begin @(negedge clk); j++; end
        scan_ready = 1'b0;
        j = 0;
        while (!scan_valid && j < 50) begin @(negedge clk); j++; end
        check("mid_valid", {7'd0, scan_valid}, 8'd1);
        check("mid_code", scan_code, 8'hE0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {7'd0, scan_valid}, 8'd0);
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        check("mid_rst_code", scan_code, 8'h00);
        rst_n = 1'b1;
        #1;
        check("mid_rel_hready", {7'd0, hack_ready}, 8'd1);
        scan_ready = 1'b1;
        q_a.delete(); q_z.delete();
        send(8'h62);
        wait_idle(0);
        expect_bytes(8'h62);
        compare_q("after_rst", q_a);
        compare_q("after_rst_z", q_z);

        // Randomized loopback over every mapped code, random back-pressure
        order = mapped;
        for (int i = order.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        foreach (order[k]) begin
            if ($urandom_range(0, 4) == 0) begin
                u = 8'($urandom_range(0, 255));
                while (enc_ok[u]) u = 8'($urandom_range(0, 255));
                send(u);
                check("rnd_unsup", {7'd0, unsupported}, 8'd1);
                check("rnd_unsup_valid", {7'd0, scan_valid}, 8'd0);
            end
            q_a.delete(); q_z.delete();
            send(order[k]);
            wait_idle(2);
            decode(q_a);
            check("lb_events", 8'(ev_h.size()), 8'd2);
            if (ev_h.size() == 2) begin
                check("lb_make", ev_h[0], order[k]);
                check("lb_make_p", {7'd0, ev_p[0]}, 8'd1);
                check("lb_break", ev_h[1], order[k]);
                check("lb_break_p", {7'd0, ev_p[1]}, 8'd0);
            end
            decode(q_z);
            check("lbz_events", 8'(ev_h.size()), 8'd2);
            if (ev_h.size() == 2) begin
                check("lbz_make", ev_h[0], order[k]);
                check("lbz_break_p", {7'd0, ev_p[1]}, 8'd0);
            end
            check("lb_nbytes", 8'(q_a.size()), enc_ext[order[k]] ? 8'd5 : 8'd3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
